// File: rtl/window_gen.sv
// Sliding KxK window generator: accepts a raster pixel stream and emits one
// window per pixel whose KxK neighbourhood lies fully inside the frame.
module window_gen #(
  parameter int KERNEL_SIZE = 3,
  parameter int PX_SIZE     = 8,
  parameter int IMG_WIDTH   = 8,
  parameter int IMG_HEIGHT  = 8
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic [PX_SIZE-1:0]                               px_in,
  input  logic                                             px_valid,
  output logic                                             px_ready,
  output logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][PX_SIZE-1:0] win_out,
  output logic                                             win_valid,
  input  logic                                             win_ready,
  output logic                                             win_last
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_MAX   = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX   = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(KERNEL_SIZE - 1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(KERNEL_SIZE - 1);

  typedef logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][PX_SIZE-1:0] win_t;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          win_valid_q, win_valid_d;
  logic          win_last_q, win_last_d;
  win_t          win_q, win_d;

  logic          accept;
  logic          col_wrap;
  logic          row_wrap;
  logic          win_load;

  // col_px[r] is the pixel at the current column, r rows above the current one
  logic [KERNEL_SIZE-1:0][PX_SIZE-1:0] col_px;

  assign px_ready  = !win_valid_q || win_ready;
  assign accept    = px_valid && px_ready;
  assign col_wrap  = (col_q == COL_MAX);
  assign row_wrap  = (row_q == ROW_MAX);
  assign win_load  = accept && (col_q >= COL_FIRST) && (row_q >= ROW_FIRST);

  assign col_px[0] = px_in;

  // Each line buffer reads ahead at the next column to be accepted, so its
  // registered output is ready by the time that pixel arrives. Buffer gi feeds
  // buffer gi+1, shifting a column up by one row on every accept.
  genvar gi;
  generate
    for (gi = 0; gi < KERNEL_SIZE - 1; gi++) begin : g_lb
      logic [PX_SIZE-1:0] mem [IMG_WIDTH];
      logic [PX_SIZE-1:0] rd_q;

      always_ff @(posedge clk) begin
        if (accept) begin
          mem[col_q] <= col_px[gi];
        end
        rd_q <= mem[col_d];
      end

      assign col_px[gi+1] = rd_q;
    end
  endgenerate

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    win_valid_d = win_valid_q;
    win_last_d  = win_last_q;
    win_d       = win_q;

    if (accept) begin
      col_d = col_wrap ? '0 : col_q + CW'(1);
      if (col_wrap) begin
        row_d = row_wrap ? '0 : row_q + RW'(1);
      end
      for (int r = 0; r < KERNEL_SIZE; r++) begin
        win_d[r][0] = col_px[r];
        for (int c = 1; c < KERNEL_SIZE; c++) begin
          win_d[r][c] = win_q[r][c-1];
        end
      end
    end

    if (win_load) begin
      win_valid_d = 1'b1;
      win_last_d  = col_wrap && row_wrap;
    end else if (win_ready) begin
      win_valid_d = 1'b0;
      win_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      win_q       <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
      win_q       <= win_d;
    end
  end

  assign win_out   = win_q;
  assign win_valid = win_valid_q;
  assign win_last  = win_last_q;

endmodule
